// File: rtl/net_echo_pkg.sv
// Shared types for the network echo responder: address template, queue entry,
// egress FSM states and the header swap used to turn a request into a response.
package net_echo_pkg;

    localparam int STAT_W         = 32;
    localparam int ECHO_PAYLOAD_W = 512;
    localparam int ECHO_TS_W      = 16;

    typedef struct packed {
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] src_port;
        logic [15:0] dst_port;
    } t_net_addr_tpl;

    typedef struct packed {
        t_net_addr_tpl               addr_tpl;
        logic [ECHO_PAYLOAD_W-1:0]   payload;
        logic [ECHO_TS_W-1:0]        ts;
    } t_echo_entry;

    typedef enum logic {
        IDLE = 1'b0,
        GAP  = 1'b1
    } t_echo_state;

    function automatic t_net_addr_tpl swap_addr(input t_net_addr_tpl a);
        t_net_addr_tpl s;
        s.src_ip   = a.dst_ip;
        s.dst_ip   = a.src_ip;
        s.src_port = a.dst_port;
        s.dst_port = a.src_port;
        return s;
    endfunction

endpackage

// File: rtl/echo_fifo.sv
// Synchronous FIFO with registered pointers and a combinational head view.
// Asynchronous active-low reset clears the pointers only; storage is data.
module echo_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

    // Extra pointer bit distinguishes full from empty when the indices meet
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/network_echo_responder.sv
// Remote-host echo endpoint: queues packets for MY_ID, returns them swapped after a
// minimum latency with paced gaps. Stat counters exist only with NETWORK_ECHO_STATS_EN.
module network_echo_responder
    import net_echo_pkg::*;
#(
    parameter logic [7:0] MY_ID      = 8'h0A,
    parameter int         PAYLOAD_W  = ECHO_PAYLOAD_W,
    parameter int         FIFO_DEPTH = 16,
    parameter int         TS_W       = ECHO_TS_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic [31:0]          req_src_ip,
    input  logic [31:0]          req_dst_ip,
    input  logic [15:0]          req_src_port,
    input  logic [15:0]          req_dst_port,
    input  logic [PAYLOAD_W-1:0] req_payload,
    input  logic [7:0]           cfg_latency,
    input  logic [3:0]           cfg_gap,
    output logic                 resp_valid,
    output logic [31:0]          resp_src_ip,
    output logic [31:0]          resp_dst_ip,
    output logic [15:0]          resp_src_port,
    output logic [15:0]          resp_dst_port,
    output logic [PAYLOAD_W-1:0] resp_payload,
    output logic [STAT_W-1:0]    stat_rx_cnt,
    output logic [STAT_W-1:0]    stat_tx_cnt,
    output logic [STAT_W-1:0]    stat_drop_cnt,
    output logic [STAT_W-1:0]    stat_misroute_cnt
);

    logic [1:0]      rst_sync;
    logic            rst_n;
    logic [TS_W-1:0] now;
    logic [TS_W-1:0] age;
    logic [7:0]      l_eff;
    logic            id_match, push, pop, head_elig;
    logic            fifo_full, fifo_empty;
    t_net_addr_tpl   req_tpl;
    t_echo_entry     push_entry, head_entry;
    t_echo_state     state, state_nxt;
    logic [3:0]      gap_cnt, gap_cnt_nxt;

    // Assert asynchronously, release on the clock
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) now <= '0;
        else        now <= now + 1'b1;
    end

    assign req_tpl  = '{src_ip: req_src_ip, dst_ip: req_dst_ip,
                        src_port: req_src_port, dst_port: req_dst_port};
    assign id_match = (req_dst_ip[7:0] == MY_ID);
    assign push     = req_valid && id_match && !fifo_full;

    always_comb begin
        push_entry          = '0;
        push_entry.addr_tpl = swap_addr(req_tpl);
        push_entry.payload  = req_payload;
        push_entry.ts       = now;
    end

    echo_fifo #(.W($bits(t_echo_entry)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head_entry)
    );

    // Wrap-safe age of the head entry against the effective latency
    assign l_eff     = (cfg_latency == 8'd0) ? 8'd1 : cfg_latency;
    assign age       = now - head_entry.ts;
    assign head_elig = !fifo_empty && (age >= TS_W'(l_eff));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        gap_cnt_nxt = gap_cnt;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                if (head_elig) begin
                    pop = 1'b1;
                    if (cfg_gap != 4'd0) begin
                        state_nxt   = GAP;
                        gap_cnt_nxt = cfg_gap;
                    end
                end
            end
            GAP: begin
                gap_cnt_nxt = gap_cnt - 1'b1;
                if (gap_cnt <= 4'd1)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: entry popped from the FIFO
    t_net_addr_tpl        addr_p0;
    logic [PAYLOAD_W-1:0] pl_p0;
    logic                 vld_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_p0 <= 1'b0;
        else        vld_p0 <= pop;
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            addr_p0 <= head_entry.addr_tpl;
            pl_p0   <= head_entry.payload;
        end
    end

    // Stage p1: response registers, held between pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid    <= 1'b0;
            resp_src_ip   <= '0;
            resp_dst_ip   <= '0;
            resp_src_port <= '0;
            resp_dst_port <= '0;
            resp_payload  <= '0;
        end else begin
            resp_valid <= vld_p0;
            if (vld_p0) begin
                resp_src_ip   <= addr_p0.src_ip;
                resp_dst_ip   <= addr_p0.dst_ip;
                resp_src_port <= addr_p0.src_port;
                resp_dst_port <= addr_p0.dst_port;
                resp_payload  <= pl_p0;
            end
        end
    end

`ifdef NETWORK_ECHO_STATS_EN
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
        return (en && (v != {STAT_W{1'b1}})) ? v + 1'b1 : v;
    endfunction

    logic drop_evt, misroute_evt;
    assign drop_evt     = req_valid && id_match && fifo_full;
    assign misroute_evt = req_valid && !id_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_rx_cnt       <= '0;
            stat_tx_cnt       <= '0;
            stat_drop_cnt     <= '0;
            stat_misroute_cnt <= '0;
        end else begin
            stat_rx_cnt       <= sat_inc(stat_rx_cnt, push);
            stat_tx_cnt       <= sat_inc(stat_tx_cnt, vld_p0);
            stat_drop_cnt     <= sat_inc(stat_drop_cnt, drop_evt);
            stat_misroute_cnt <= sat_inc(stat_misroute_cnt, misroute_evt);
        end
    end
`else
    assign stat_rx_cnt       = '0;
    assign stat_tx_cnt       = '0;
    assign stat_drop_cnt     = '0;
    assign stat_misroute_cnt = '0;
`endif

endmodule

// File: tb/tb_network_echo_responder.sv
// Bench for network_echo_responder: random traffic scored against a closed-form
// timing model (pop edge = max(accept + Leff, previous pop + gap + 1)).
`timescale 1ns/1ps
module tb_network_echo_responder;

    localparam logic [7:0] MY_ID = 8'h0A;
    localparam int         PW    = 512;
    localparam int         DEPTH = 16;
`ifdef NETWORK_ECHO_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic [31:0]   req_src_ip, req_dst_ip;
    logic [15:0]   req_src_port, req_dst_port;
    logic [PW-1:0] req_payload;
    logic [7:0]    cfg_latency;
    logic [3:0]    cfg_gap;
    logic          resp_valid;
    logic [31:0]   resp_src_ip, resp_dst_ip;
    logic [15:0]   resp_src_port, resp_dst_port;
    logic [PW-1:0] resp_payload;
    logic [31:0]   stat_rx_cnt, stat_tx_cnt, stat_drop_cnt, stat_misroute_cnt;

    always #5 clk = ~clk;

    network_echo_responder dut (
        .clk (clk), .reset (reset),
        .req_valid (req_valid), .req_src_ip (req_src_ip), .req_dst_ip (req_dst_ip),
        .req_src_port (req_src_port), .req_dst_port (req_dst_port), .req_payload (req_payload),
        .cfg_latency (cfg_latency), .cfg_gap (cfg_gap),
        .resp_valid (resp_valid), .resp_src_ip (resp_src_ip), .resp_dst_ip (resp_dst_ip),
        .resp_src_port (resp_src_port), .resp_dst_port (resp_dst_port), .resp_payload (resp_payload),
        .stat_rx_cnt (stat_rx_cnt), .stat_tx_cnt (stat_tx_cnt),
        .stat_drop_cnt (stat_drop_cnt), .stat_misroute_cnt (stat_misroute_cnt)
    );

    typedef struct {
        longint        at;
        logic [31:0]   sip, dip;
        logic [15:0]   sp, dp;
        logic [PW-1:0] pl;
    } resp_t;

    int     total = 0;
    int     bad   = 0;
    longint cyc   = 0;
    longint rel_cyc = 0;
    resp_t  obs_q[$];
    resp_t  exp_q[$];
    longint pend_pops[$];
    longint next_free = -1000;
    int     m_rx = 0, m_tx = 0, m_drop = 0, m_mis = 0;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin : rec
        resp_t r;
        #1;
        if (resp_valid === 1'b1) begin
            r.at = cyc; r.sip = resp_src_ip; r.dip = resp_dst_ip;
            r.sp = resp_src_port; r.dp = resp_dst_port; r.pl = resp_payload;
            obs_q.push_back(r);
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] stat_exp(input int v);
        return STATS_ON ? 32'(v) : 32'd0;
    endfunction

    function automatic logic [PW-1:0] rand_payload();
        logic [PW-1:0] p;
        for (int k = 0; k < PW/32; k++) p[k*32 +: 32] = $urandom;
        return p;
    endfunction

    task automatic model_reset();
        exp_q.delete(); pend_pops.delete();
        next_free = -1000;
        m_rx = 0; m_tx = 0; m_drop = 0; m_mis = 0;
    endtask

    task automatic drive_pkt(input logic [31:0] sip, input logic [31:0] dip,
                             input logic [15:0] sp, input logic [15:0] dp,
                             input logic [PW-1:0] pl);
        longint a, p;
        int     leff;
        resp_t  e;
        @(negedge clk);
        req_valid = 1'b1; req_src_ip = sip; req_dst_ip = dip;
        req_src_port = sp; req_dst_port = dp; req_payload = pl;
        a = cyc + 1;
        if (dip[7:0] != MY_ID) begin
            m_mis++;
        end else begin
            while (pend_pops.size() > 0 && pend_pops[0] < a) void'(pend_pops.pop_front());
            if (pend_pops.size() >= DEPTH) begin
                m_drop++;
            end else begin
                leff = (cfg_latency == 8'd0) ? 1 : int'(cfg_latency);
                p = a + leff;
                if (next_free > p) p = next_free;
                next_free = p + cfg_gap + 1;
                pend_pops.push_back(p);
                e.at = p + 1; e.sip = dip; e.dip = sip; e.sp = dp; e.dp = sp; e.pl = pl;
                exp_q.push_back(e);
                m_rx++; m_tx++;
            end
        end
    endtask

    task automatic rand_pkt(input bit match);
        logic [31:0] sip, dip;
        sip = $urandom; dip = $urandom;
        if (match) dip[7:0] = MY_ID;
        else if (dip[7:0] == MY_ID) dip[7:0] = MY_ID ^ 8'h01;
        drive_pkt(sip, dip, 16'($urandom), 16'($urandom), rand_payload());
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    task automatic wait_drain(input int budget, output bit timed_out);
        int n = 0;
        timed_out = 1'b0;
        while (obs_q.size() < exp_q.size()) begin
            if (n >= budget) begin timed_out = 1'b1; break; end
            @(negedge clk);
            req_valid = 1'b0;
            n++;
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle(4);
        total++;
        if (resp_valid !== 1'b0 || resp_src_ip !== '0 || resp_dst_ip !== '0 ||
            resp_src_port !== '0 || resp_dst_port !== '0 || resp_payload !== '0) begin
            bad++;
            $display("FAIL reset_resp: valid=%b sip=%h dip=%h required all zero",
                     resp_valid, resp_src_ip, resp_dst_ip);
        end
        total++;
        if ({stat_rx_cnt, stat_tx_cnt, stat_drop_cnt, stat_misroute_cnt} !== 128'd0) begin
            bad++;
            $display("FAIL reset_stats: rx=%0d tx=%0d drop=%0d mis=%0d required 0",
                     stat_rx_cnt, stat_tx_cnt, stat_drop_cnt, stat_misroute_cnt);
        end
        reset = 1'b1;
        rel_cyc = cyc;
        model_reset();
        idle(5);
    endtask

    task automatic test_single();
        logic [PW-1:0] pl;
        longint        a;
        bit            to;
        obs_q.delete(); exp_q.delete();
        cfg_latency = 8'd4; cfg_gap = 4'd0;
        pl = rand_payload();
        drive_pkt(32'h0A00_0100, 32'h0A00_000A, 16'd100, 16'd200, pl);
        a = cyc + 1;
        wait_drain(200, to);
        total++;
        if (to || obs_q.size() != 1) begin
            bad++;
            $display("FAIL single_count: got %0d responses, required 1", obs_q.size());
        end
        if (obs_q.size() > 0) begin
            total++;
            if (obs_q[0].at - a != 5) begin
                bad++;
                $display("FAIL single_latency: got %0d cycles, required 5", obs_q[0].at - a);
            end
            total++;
            if (obs_q[0].sip[7:0] !== 8'h0A || obs_q[0].dip[7:0] !== 8'h00 ||
                obs_q[0].sp !== 16'd200 || obs_q[0].dp !== 16'd100 || obs_q[0].pl !== pl) begin
                bad++;
                $display("FAIL single_fields: got sip=%h dip=%h sp=%0d dp=%0d, required b0 0a/00 ports 200/100",
                         obs_q[0].sip, obs_q[0].dip, obs_q[0].sp, obs_q[0].dp);
            end
        end
        total++;
        if (stat_rx_cnt !== stat_exp(1) || stat_tx_cnt !== stat_exp(1)) begin
            bad++;
            $display("FAIL single_stats: rx=%0d tx=%0d required %0d", stat_rx_cnt, stat_tx_cnt, stat_exp(1));
        end
    endtask

    task automatic test_misroute();
        bit to;
        obs_q.delete(); exp_q.delete();
        for (int i = 0; i < 3; i++)
            drive_pkt($urandom, {24'h0A0000, 8'h05}, 16'($urandom), 16'($urandom), rand_payload());
        wait_drain(100, to);
        total++;
        if (obs_q.size() != 0) begin
            bad++;
            $display("FAIL misroute_resp: got %0d responses, required 0", obs_q.size());
        end
        total++;
        if (stat_misroute_cnt !== stat_exp(3) || stat_rx_cnt !== stat_exp(m_rx)) begin
            bad++;
            $display("FAIL misroute_stats: mis=%0d rx=%0d required %0d/%0d",
                     stat_misroute_cnt, stat_rx_cnt, stat_exp(3), stat_exp(m_rx));
        end
    endtask

    task automatic test_overflow();
        bit to;
        obs_q.delete(); exp_q.delete();
        cfg_latency = 8'd200; cfg_gap = 4'd0;
        for (int i = 0; i < 20; i++) rand_pkt(1'b1);
        wait_drain(1000, to);
        total++;
        if (to || obs_q.size() != 16) begin
            bad++;
            $display("FAIL overflow_count: got %0d responses, required 16", obs_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i].at != exp_q[i].at || obs_q[i].sip !== exp_q[i].sip || obs_q[i].dip !== exp_q[i].dip ||
                obs_q[i].sp !== exp_q[i].sp || obs_q[i].dp !== exp_q[i].dp || obs_q[i].pl !== exp_q[i].pl) begin
                bad++;
                $display("FAIL overflow_resp[%0d]: got edge %0d sip %h, required edge %0d sip %h",
                         i, obs_q[i].at, obs_q[i].sip, exp_q[i].at, exp_q[i].sip);
            end
        end
        total++;
        if (stat_drop_cnt !== stat_exp(4) || stat_tx_cnt !== stat_exp(m_tx)) begin
            bad++;
            $display("FAIL overflow_stats: drop=%0d tx=%0d required %0d/%0d",
                     stat_drop_cnt, stat_tx_cnt, stat_exp(4), stat_exp(m_tx));
        end
    endtask

    task automatic test_gap();
        bit to;
        logic [3:0] gaps [2];
        gaps[0] = 4'd3; gaps[1] = 4'd0;
        for (int g = 0; g < 2; g++) begin
            obs_q.delete(); exp_q.delete();
            cfg_latency = 8'd1; cfg_gap = gaps[g];
            for (int i = 0; i < 4; i++) rand_pkt(1'b1);
            wait_drain(200, to);
            total++;
            if (to || obs_q.size() != 4) begin
                bad++;
                $display("FAIL gap%0d_count: got %0d responses, required 4", gaps[g], obs_q.size());
            end
            for (int i = 1; i < obs_q.size(); i++) begin
                total++;
                if (obs_q[i].at - obs_q[i-1].at != longint'(gaps[g]) + 1) begin
                    bad++;
                    $display("FAIL gap%0d_spacing[%0d]: got %0d cycles, required %0d",
                             gaps[g], i, obs_q[i].at - obs_q[i-1].at, gaps[g] + 1);
                end
            end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                total++;
                if (obs_q[i].at != exp_q[i].at || obs_q[i].pl !== exp_q[i].pl) begin
                    bad++;
                    $display("FAIL gap%0d_resp[%0d]: got edge %0d, required edge %0d",
                             gaps[g], i, obs_q[i].at, exp_q[i].at);
                end
            end
        end
    endtask

    task automatic test_random();
        bit to;
        for (int round = 0; round < 2; round++) begin
            obs_q.delete(); exp_q.delete();
            cfg_latency = 8'($urandom_range(0, 10));
            cfg_gap     = 4'($urandom_range(0, 4));
            for (int i = 0; i < 60; i++) begin
                rand_pkt($urandom_range(0, 9) < 8);
                idle($urandom_range(0, 3));
            end
            wait_drain(2000, to);
            total++;
            if (to || obs_q.size() != exp_q.size()) begin
                bad++;
                $display("FAIL random%0d_count: got %0d responses, required %0d",
                         round, obs_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                total++;
                if (obs_q[i].at != exp_q[i].at || obs_q[i].sip !== exp_q[i].sip || obs_q[i].dip !== exp_q[i].dip ||
                    obs_q[i].sp !== exp_q[i].sp || obs_q[i].dp !== exp_q[i].dp || obs_q[i].pl !== exp_q[i].pl) begin
                    bad++;
                    $display("FAIL random%0d_resp[%0d]: got edge %0d sip %h, required edge %0d sip %h",
                             round, i, obs_q[i].at, obs_q[i].sip, exp_q[i].at, exp_q[i].sip);
                end
            end
        end
        total++;
        if (stat_rx_cnt !== stat_exp(m_rx) || stat_tx_cnt !== stat_exp(m_tx) ||
            stat_drop_cnt !== stat_exp(m_drop) || stat_misroute_cnt !== stat_exp(m_mis)) begin
            bad++;
            $display("FAIL random_stats: rx=%0d tx=%0d drop=%0d mis=%0d required %0d/%0d/%0d/%0d",
                     stat_rx_cnt, stat_tx_cnt, stat_drop_cnt, stat_misroute_cnt,
                     stat_exp(m_rx), stat_exp(m_tx), stat_exp(m_drop), stat_exp(m_mis));
        end
    endtask

    task automatic test_reset_midop();
        obs_q.delete(); exp_q.delete();
        cfg_latency = 8'd200; cfg_gap = 4'd0;
        for (int i = 0; i < 5; i++) rand_pkt(1'b1);
        idle(3);
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (resp_valid !== 1'b0 || resp_src_ip !== '0 || resp_payload !== '0) begin
            bad++;
            $display("FAIL midop_resp: valid=%b sip=%h required zero", resp_valid, resp_src_ip);
        end
        total++;
        if ({stat_rx_cnt, stat_tx_cnt, stat_drop_cnt, stat_misroute_cnt} !== 128'd0) begin
            bad++;
            $display("FAIL midop_stats: rx=%0d tx=%0d drop=%0d mis=%0d required 0",
                     stat_rx_cnt, stat_tx_cnt, stat_drop_cnt, stat_misroute_cnt);
        end
        model_reset();
        obs_q.delete();
        idle(3);
        reset = 1'b1;
        rel_cyc = cyc;
        idle(300);
        total++;
        if (obs_q.size() != 0) begin
            bad++;
            $display("FAIL midop_stale: got %0d responses after reset, required 0", obs_q.size());
        end
    endtask

    task automatic test_wrap();
        longint a_t;
        longint acc[$];
        bit     to;
        obs_q.delete(); exp_q.delete();
        cfg_latency = 8'd5; cfg_gap = 4'd0;
        // Edge whose stored timestamp is 16'hFFFE, counting the two-flop reset release
        a_t = rel_cyc + 3 + 65534;
        while (cyc + 5 < a_t) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            rand_pkt(1'b1);
            acc.push_back(cyc + 1);
        end
        wait_drain(200, to);
        total++;
        if (to || obs_q.size() != 9) begin
            bad++;
            $display("FAIL wrap_count: got %0d responses, required 9", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < acc.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i].at - acc[i] != 6 || obs_q[i].pl !== exp_q[i].pl) begin
                bad++;
                $display("FAIL wrap_latency[%0d]: got %0d cycles, required 6", i, obs_q[i].at - acc[i]);
            end
        end
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0;
        req_src_ip = '0; req_dst_ip = '0; req_src_port = '0; req_dst_port = '0; req_payload = '0;
        cfg_latency = 8'd4; cfg_gap = 4'd0;
        test_reset();
        test_single();
        test_misroute();
        test_overflow();
        test_gap();
        test_random();
        test_reset_midop();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/network_echo_responder.md
Name: network_echo_responder

Overview:
Remote-host emulator on the network side of the ToR loopback. It consumes NIC Tx packets addressed to its own ID and returns them on a NIC Rx line with source and destination swapped. Responses are released after a programmable minimum latency and spaced by a programmable inter-packet gap, which emulates a server endpoint for client-NIC RPC tests. The interface is valid-only in both directions with no backpressure, matching the switch fabric; when the queue is full, the block drops packets and counts the drops.

Parameters:
MY_ID, 8'h0A, responder address; compared against req_dst_ip[7:0] (b0).
PAYLOAD_W, 512, packet payload width (one cache line).
FIFO_DEPTH, 16, queue entries; power of 2, minimum 2.
TS_W, 16, free-running timestamp width.

Ports:
clk  in  1  network clock (clk_div_2 domain)
reset  in  1  asynchronous, active-low reset (asserted when 0)
req_valid  in  1  Tx packet present this cycle
req_src_ip  in  32  source IP
req_dst_ip  in  32  destination IP; b0 selects endpoint
req_src_port  in  16  source port
req_dst_port  in  16  destination port
req_payload  in  PAYLOAD_W  payload
cfg_latency  in  8  minimum cycles from accept to response
cfg_gap  in  4  idle cycles forced between responses
resp_valid  out  1  response present (one-cycle pulse per packet)
resp_src_ip  out  32  = request dst_ip
resp_dst_ip  out  32  = request src_ip
resp_src_port  out  16  = request dst_port
resp_dst_port  out  16  = request src_port
resp_payload  out  PAYLOAD_W  = request payload, unmodified
stat_rx_cnt  out  32  accepted packets
stat_tx_cnt  out  32  emitted responses
stat_drop_cnt  out  32  packets dropped because the FIFO was full
stat_misroute_cnt  out  32  valid packets with dst b0 != MY_ID

Behaviour:
- Reset (async assert, sync deassert internally):
  - resp_valid=0, all resp_* fields=0, all stat counters=0.
  - FIFO emptied, now=0, FSM=IDLE.
  - Reset mid-operation discards queued packets with no partial output.
- now: TS_W-bit counter, +1 every cycle, wraps silently.
- Ingress, evaluated each cycle with req_valid=1:
  - dst b0 != MY_ID: stat_misroute_cnt+1, no push.
  - dst matches and FIFO full: stat_drop_cnt+1, no push. Fullness is sampled before any same-cycle pop, so push and pop when full results in a drop.
  - Otherwise: push {swapped header, payload, ts=now} and stat_rx_cnt+1.
- Eligibility: the head entry is eligible when (now - head.ts) mod 2^TS_W >= Leff, where Leff = max(cfg_latency,1). The wrap-safe subtraction is TS_W bits wide.
- Egress FSM:
  - IDLE: if FIFO not empty and head eligible, pop, register the entry onto resp_*, and set resp_valid=1 the next cycle with stat_tx_cnt+1. Then go to GAP if cfg_gap!=0, else stay in IDLE (back-to-back responses allowed).
  - GAP: gap_cnt loaded with cfg_gap at the pop, decremented each cycle; return to IDLE when it reaches 0.
  - resp_valid is high for exactly one cycle per response. resp_* fields hold their last value while resp_valid=0.
- Latency: a packet accepted at edge t into an empty FIFO with the FSM in IDLE gives resp_valid=1 at edge t+Leff+1.
- Ordering is strict FIFO; a later packet is never emitted before an earlier one.
- Config: cfg_latency and cfg_gap are sampled live. A change applies to the next eligibility check or gap load and does not retime an in-flight gap.
- All counters saturate at 32'hFFFF_FFFF.
- Simultaneous push into an empty FIFO with an eligibility check in the same cycle: the new entry is not visible until the next cycle.

Optional Feature:
- Macro: NETWORK_ECHO_STATS_EN.
- Defined: the four stat counters are implemented as specified above.
- Undefined: stat_* outputs are tied to 0 and the counter logic is omitted. Datapath behaviour is identical in both builds.

Decomposition:
- Package net_echo_pkg contains:
  - t_net_addr_tpl (src_ip, dst_ip, src_port, dst_port)
  - t_echo_entry (addr_tpl, payload, ts)
  - the FSM state enum {IDLE, GAP}
  - the swap function
  - constant STAT_W=32
- Sub-module: echo_fifo, a synchronous FIFO with push/pop/full/empty/head and the same async active-low reset.
- Top level holds ingress filtering, the timestamp counter, the FSM and the counters.

Test Plan:
- Single packet: src_ip b0=0x00, dst b0=0x0A, ports 100->200, cfg_latency=4, cfg_gap=0, accepted at edge 10 -> resp_valid pulses once at edge 15; src b0=0x0A, dst b0=0x00, ports 200->100, payload identical; stat_rx=1, stat_tx=1.
- Misroute: 3 packets with dst b0=0x05 -> no resp_valid; stat_misroute=3, stat_rx=0.
- Overflow: cfg_latency=200, 20 matching packets back-to-back -> 16 queued, stat_drop=4; the 16 responses later emerge in order.
- Gap pacing: 4 packets queued, cfg_latency=1, cfg_gap=3 -> resp_valid at edges spaced exactly 4 cycles apart; with cfg_gap=0, 4 consecutive cycles.
- Timestamp wrap: preload traffic so a packet is accepted at now=16'hFFFE with cfg_latency=5 -> response at accept+6 despite the wrap.
- Async reset: assert reset with 5 packets queued -> resp_valid=0 immediately, counters 0; after release, no stale responses appear within 300 cycles.
